rand_req_arbiter: RTL
=====================

# rand_req_arbiter

Shares one 5-bit LFSR random generator among up to NUM_REQ game-logic requesters, such as obstacle spawners and item droppers. Requesters are served round-robin. For each grant the block advances the generator a fixed number of steps, then reduces the result into the requester's range plus a fixed offset. It returns the value through a valid/ready response channel. It also reseeds the generator if the generator locks up at zero.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- WIDTH, default 5: generator state width and range width.
- STEPS, default 3: generator advances per grant, 1..15.
- OFFSET, default 6: constant added to every result.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_range  in  NUM_REQ*WIDTH  packed ranges; requester i uses bits [i*WIDTH +: WIDTH].
- grant  out  NUM_REQ  one-hot, the requester currently being served.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH+1  result, equal to (lfsr_q % range) + OFFSET.
- rsp_id  out  clog2(NUM_REQ)  index of the served requester.
- lfsr_step  out  1  advance the generator this cycle.
- lfsr_load  out  1  load seed into the generator this cycle.
- lfsr_q  in  WIDTH  current generator state.
- seed  in  WIDTH  reseed value.

## Operation
- FSM states:
  - IDLE: when any req bit is high, pick the first requester at or after rr_ptr (wrapping), latch its range and id, clear the step counter, and go to STEP.
  - STEP: stay here for STEPS cycles, counting each one, then go to CALC.
  - CALC: register rsp_data, then go to RESP.
  - RESP: hold rsp_valid high; on rsp_ready go to IDLE and set rr_ptr to granted id + 1 (mod NUM_REQ).
- Each STEP cycle drives exactly one of lfsr_step or lfsr_load:
  - lfsr_step=1 normally.
  - If lfsr_q==0, drive lfsr_load=1 instead, with lfsr_step=0. The cycle still counts as a step.
  - If seed==0, the generator must not be loaded with zero. The block drives the seed port value 1 through an internal mux on its own seed output path, so seed_eff = (seed==0) ? 1 : seed. The generator loads seed_eff.
- Arithmetic in CALC:
  - range==0: result is OFFSET.
  - Otherwise: unsigned lfsr_q % range, zero-extended to WIDTH+1 bits, plus OFFSET. No truncation.
- grant is held one-hot from STEP entry until the RESP handshake completes. It is 0 in IDLE.
- req and req_range are sampled only in IDLE. Later changes do not affect the transaction in flight.
- If a requester drops req while granted, the transaction still completes.
- rsp_data and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation aborts the transaction. No response is emitted.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant=0, rsp_valid=0, rsp_data=0, rsp_id=0, lfsr_step=0, lfsr_load=0.
- Request seen in IDLE at cycle 0:
  - STEP occupies cycles 1..STEPS.
  - CALC is cycle STEPS+1.
  - rsp_valid rises at cycle STEPS+2.
- With rsp_ready held high, the handshake completes in that cycle. The next request can be accepted in the following cycle. Throughput is one result per STEPS+3 cycles.
- lfsr_step and lfsr_load are decoded from registered state and lfsr_q. The generator sees its state change at the end of each STEP cycle. CALC therefore sees the post-step value.
- rsp_ready is ignored outside RESP.

## Configuration
- RAND_REPEAT_FILTER_EN, when defined:
  - The block keeps each requester's last result.
  - If the CALC result equals the stored value for that requester, it runs one extra STEP cycle and recomputes, with at most one retry per grant. Latency becomes STEPS+3 in that case.
  - The stored value updates on each handshake. Stored values reset to 0.
- Undefined: no history storage and fixed latency STEPS+2.

## Structure
- Shared package rand_pkg holds:
  - the FSM state enum: IDLE, STEP, CALC, RESP.
  - the reseed fallback constant SEED_FALLBACK=1.
  - the default OFFSET.
- Sub-module rr_pick: combinational round-robin selector with inputs req and rr_ptr, outputs one-hot and index. Instantiated once.
- The generator itself is external and connected through lfsr_step, lfsr_load, lfsr_q and seed.

## Test plan
- Single request, range=4, generator model at lfsr_q=13 in CALC, STEPS=3, rsp_ready=1 -> rsp_valid at cycle 5, rsp_data=7, rsp_id=0; lfsr_step high for exactly 3 cycles.
- req=4'b1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 and grant one-hot each time.
- range=0 -> rsp_data=6. range=31 with lfsr_q=30 -> rsp_data=36 (6 bits, no wrap).
- Generator forced to 0 during STEP with seed=5'b10110 -> lfsr_load pulses that cycle, the generator reloads 22, and the step count is unchanged. With seed=0 -> the generator loads 1.
- rsp_ready held low 10 cycles, with req_range changed and another req raised -> rsp_valid stays 1, rsp_data/rsp_id stable, and no new grant until the handshake.
- rst asserted in STEP -> all outputs return to reset values immediately. With the macro defined, two identical results for one requester -> one extra lfsr_step and a different rsp_data.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared types and constants for the random-request arbiter slice.
package rand_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    CALC = 2'd2,
    RESP = 2'd3
  } state_e;

  // Loaded instead of a zero seed so the generator can never lock up at zero.
  localparam int unsigned SEED_FALLBACK  = 1;
  localparam int unsigned DEFAULT_OFFSET = 6;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr, wrapping.
module rr_pick
  import rand_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDW-1:0]     idx,
  output logic               found
);

  logic [IDW-1:0] cand;

  // Scan from rr_ptr upward and keep the first asserted request.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDW'((32'(rr_ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/rand_req_arbiter.sv
// Round-robin sharing of an external LFSR among NUM_REQ requesters.
// Each grant advances the generator STEPS times, reduces the value into the
// requester's range plus OFFSET and returns it on a valid/ready channel.
// Optional feature: RAND_REPEAT_FILTER_EN (one retry when a requester would
// receive the same value twice in a row).
module rand_req_arbiter
  import rand_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned STEPS   = 3,
  parameter int unsigned OFFSET  = DEFAULT_OFFSET,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_range,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH:0]           rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     lfsr_step,
  output logic                     lfsr_load,
  input  logic [WIDTH-1:0]         lfsr_q,
  input  logic [WIDTH-1:0]         seed,
  output logic [WIDTH-1:0]         seed_eff
);

  localparam logic [WIDTH:0] OFF_W = (WIDTH+1)'(OFFSET);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]     range_q, range_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WIDTH:0]       data_q, data_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_found;
  logic [WIDTH-1:0]     sel_range;
  logic [WIDTH:0]       calc_res;
  logic                 gen_cycle;
  logic                 repeat_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign sel_range = req_range[32'(pick_idx)*WIDTH +: WIDTH];
  assign seed_eff  = (seed == '0) ? WIDTH'(SEED_FALLBACK) : seed;

  // Range reduction; a zero range yields the bare offset.
  always_comb begin
    calc_res = OFF_W;
    if (range_q != '0) calc_res = {1'b0, lfsr_q % range_q} + OFF_W;
  end

`ifdef RAND_REPEAT_FILTER_EN
  logic           retry_q, retry_d;
  logic [WIDTH:0] hist_q [NUM_REQ];

  assign repeat_hit = (calc_res == hist_q[id_q]) && !retry_q;

  // Retry flag and per-requester history of the last accepted result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) hist_q[i] <= '0;
    end else begin
      retry_q <= retry_d;
      if (state_q == RESP && rsp_ready) hist_q[id_q] <= data_q;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  // State register and transaction context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      grant_q  <= '0;
      range_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      grant_q  <= grant_d;
      range_q  <= range_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic and generator-control decode.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    grant_d   = grant_q;
    range_d   = range_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    gen_cycle = 1'b0;
`ifdef RAND_REPEAT_FILTER_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          id_d    = pick_idx;
          grant_d = pick_oh;
          range_d = sel_range;
          cnt_d   = '0;
          state_d = STEP;
`ifdef RAND_REPEAT_FILTER_EN
          retry_d = 1'b0;
`endif
        end
      end
      STEP: begin
        gen_cycle = 1'b1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'(STEPS - 1)) state_d = CALC;
      end
      CALC: begin
        // The retry step is issued from CALC itself so the recomputed result
        // lands one cycle later without re-entering STEP.
        if (repeat_hit) begin
          gen_cycle = 1'b1;
`ifdef RAND_REPEAT_FILTER_EN
          retry_d   = 1'b1;
`endif
        end else begin
          data_d  = calc_res;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lfsr_load = gen_cycle && (lfsr_q == '0);
  assign lfsr_step = gen_cycle && (lfsr_q != '0);
  assign grant     = grant_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;

endmodule
